// File: rtl/stream_para_feature_loader.sv
// Stream consumer for the weight/feature source: selects the source mode, accepts
// beats and routes them to the weight RAM (incrementing address) or the feature FIFO.
module stream_para_feature_loader #(
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned WEIGHT_ADDR_WIDTH = 19,
    parameter int unsigned FEATURE_CNT_WIDTH = 21
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WEIGHT_ADDR_WIDTH-1:0] cfg_weight_num,
    input  logic [FEATURE_CNT_WIDTH-1:0] cfg_feature_num,
    input  logic                         start_weight,
    input  logic                         start_feature,
    output logic                         EN,
    input  logic [DATA_WIDTH-1:0]        S_Data,
    input  logic                         S_Valid,
    output logic                         S_Ready,
    input  logic                         feature_almost_full,
    output logic                         weight_wr_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0] weight_wr_addr,
    output logic [DATA_WIDTH-1:0]        weight_wr_data,
    output logic                         feature_wr_en,
    output logic [DATA_WIDTH-1:0]        feature_wr_data,
    output logic                         weight_done,
    output logic                         feature_done,
    output logic                         busy
);

    // One counter serves both loads, so it is as wide as the wider of the two.
    localparam int unsigned CNT_W = (FEATURE_CNT_WIDTH > WEIGHT_ADDR_WIDTH) ?
                                    FEATURE_CNT_WIDTH : WEIGHT_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, FINISH_W, FINISH_F} state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [CNT_W-1:0]               num_q, num_d;
    logic                           en_q, en_d;
    logic                           w_en_q, w_en_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic                           f_en_q, f_en_d;
    logic [DATA_WIDTH-1:0]          f_data_q, f_data_d;
    logic                           accept;
    logic                           last_beat;

    assign accept    = S_Valid & S_Ready;
    assign last_beat = (cnt_q == num_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            en_q     <= 1'b0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            f_en_q   <= 1'b0;
            f_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            en_q     <= en_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            f_en_q   <= f_en_d;
            f_data_q <= f_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_weight) begin
                    state_d = (cfg_weight_num == '0) ? FINISH_W : LOAD_W;
                end else if (start_feature) begin
                    state_d = (cfg_feature_num == '0) ? FINISH_F : LOAD_F;
                end
            end
            LOAD_W:   if (accept && last_beat) state_d = FINISH_W;
            LOAD_F:   if (accept && last_beat) state_d = FINISH_F;
            FINISH_W: state_d = IDLE;
            FINISH_F: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        num_d    = num_q;
        en_d     = en_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        f_en_d   = 1'b0;
        f_data_d = f_data_q;
        if (state_q == IDLE) begin
            if (start_weight) begin
                num_d = CNT_W'(cfg_weight_num);
                cnt_d = '0;
                en_d  = 1'b1;
            end else if (start_feature) begin
                num_d = CNT_W'(cfg_feature_num);
                cnt_d = '0;
                en_d  = 1'b0;
            end
        end
        // Writes are the registered image of the accepted beat; the address is the pre-increment count.
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == LOAD_W) begin
                w_en_d   = 1'b1;
                w_addr_d = cnt_q[WEIGHT_ADDR_WIDTH-1:0];
                w_data_d = S_Data;
            end else begin
                f_en_d   = 1'b1;
                f_data_d = S_Data;
            end
        end
    end

    always_comb begin
        S_Ready      = 1'b0;
        busy         = (state_q != IDLE);
        weight_done  = (state_q == FINISH_W);
        feature_done = (state_q == FINISH_F);
        case (state_q)
            LOAD_W:  S_Ready = 1'b1;
            LOAD_F:  S_Ready = !feature_almost_full;
            default: S_Ready = 1'b0;
        endcase
    end

    assign EN              = en_q;
    assign weight_wr_en    = w_en_q;
    assign weight_wr_addr  = w_addr_q;
    assign weight_wr_data  = w_data_q;
    assign feature_wr_en   = f_en_q;
    assign feature_wr_data = f_data_q;

endmodule
